// File: rtl/i3c_pkg.sv
// i3c_pkg: shared state encoding, requester indices and timeout default for the SDA drive arbiter.
package i3c_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TMO  = 2'd2
  } state_t;
  localparam logic [1:0] ID_SDR  = 2'd0;
  localparam logic [1:0] ID_IBI  = 2'd1;
  localparam logic [1:0] ID_DDR  = 2'd2;
  localparam logic [1:0] ID_NONE = 2'd3;
  localparam int TMO_SCL_DEF = 64;
endpackage

// File: rtl/i3c_fixed_prio_sel.sv
// i3c_fixed_prio_sel: combinational fixed-priority pick (0 > 1 > 2) of unmasked requests.
module i3c_fixed_prio_sel
  import i3c_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] mask,
  output logic [2:0] onehot,
  output logic [1:0] idx,
  output logic       valid
);
  logic [2:0] m;
  always_comb begin
    m = req & ~mask;
    onehot = m[0] ? 3'b001 : m[1] ? 3'b010 : m[2] ? 3'b100 : 3'b000;
    idx = m[0] ? ID_SDR : m[1] ? ID_IBI : m[2] ? ID_DDR : ID_NONE;
    valid = |m;
  end
endmodule

// File: rtl/i3c_sda_drive_arb.sv
// i3c_sda_drive_arb: SDA drive ownership arbiter with SCL-edge timeout and forced release.
// Requester 2 (HDR-DDR) and its rise32 path exist only when I3C_SDA_ARB_DDR_EN is defined.
module i3c_sda_drive_arb
  import i3c_pkg::*;
#(
  parameter int TMO_SCL = TMO_SCL_DEF,
  parameter int CNT_W = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_scl_sync,
  input  logic [2:0] req,
  input  logic [2:0] req_sda_out,
  input  logic [2:0] req_oena,
  input  logic [2:0] req_rise0,
  input  logic [2:0] req_rise1,
  input  logic [1:0] req_rise32,
  output logic [2:0] gnt,
  output logic       pin_SDA_out,
  output logic       pin_SDA_oena,
  output logic       pin_SDA_oena_rise0,
  output logic       pin_SDA_oena_rise1,
  output logic [1:0] pin_SDA_oena_rise32,
  output logic       tmo_err,
  output logic [1:0] owner_id
);
`ifdef I3C_SDA_ARB_DDR_EN
  localparam logic [2:0] REQ_EN = 3'b111;
`else
  localparam logic [2:0] REQ_EN = 3'b011;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO_L = CNT_W'(TMO_SCL);
  localparam bit TMO_ON = TMO_SCL != 0;
  state_t state, state_n;
  logic [2:0] req_en, mask, mask_n, sel_gnt, gnt_r, gnt_n;
  logic [1:0] sel_idx, owner_n;
  logic sel_valid, scl_d, fall, own_req, keep, tmo_hit;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0] req_x, out_x, oena_x, r0_x, r1_x, drv, drv_n;
  assign req_en = req & REQ_EN;
  assign req_x = {1'b0, req_en};
  assign out_x = {1'b0, req_sda_out};
  assign oena_x = {1'b0, req_oena};
  assign r0_x = {1'b0, req_rise0};
  assign r1_x = {1'b0, req_rise1};
  assign fall = scl_d & ~i_scl_sync;
  assign own_req = req_x[owner_id];
  assign tmo_hit = TMO_ON && (cnt >= TMO_L);
  i3c_fixed_prio_sel u_sel (
    .req   (req_en),
    .mask  (mask),
    .onehot(sel_gnt),
    .idx   (sel_idx),
    .valid (sel_valid)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      gnt_r <= '0;
      owner_id <= ID_NONE;
      drv <= '0;
      tmo_err <= 1'b0;
      cnt <= '0;
      mask <= '0;
      scl_d <= 1'b1;
    end else begin
      state <= state_n;
      gnt_r <= gnt_n;
      owner_id <= owner_n;
      drv <= drv_n;
      tmo_err <= state_n == ST_TMO;
      cnt <= cnt_n;
      mask <= mask_n;
      scl_d <= i_scl_sync;
    end
  end
  // Release beats timeout; ownership never moves directly between requesters.
  always_comb begin
    state_n = state == ST_IDLE ? (sel_valid ? ST_OWN : ST_IDLE)
            : state == ST_OWN  ? (!own_req ? ST_IDLE : tmo_hit ? ST_TMO : ST_OWN)
            : ST_IDLE;
  end
  always_comb begin
    keep = state == ST_OWN && state_n == ST_OWN;
    gnt_n = state_n != ST_OWN ? 3'b000 : state == ST_IDLE ? sel_gnt : gnt_r;
    owner_n = state_n != ST_OWN ? ID_NONE : state == ST_IDLE ? sel_idx : owner_id;
    drv_n = keep ? {r1_x[owner_id], r0_x[owner_id], oena_x[owner_id], out_x[owner_id]} : 4'b0000;
    mask_n = (mask & req_en) | (state_n == ST_TMO ? gnt_r : 3'b000);
    cnt_n = state != ST_OWN ? '0 : (fall && cnt != CNT_MAX) ? cnt + 1'b1 : cnt;
  end
  assign gnt = gnt_r & REQ_EN;
  assign {pin_SDA_oena_rise1, pin_SDA_oena_rise0, pin_SDA_oena, pin_SDA_out} = drv;
`ifdef I3C_SDA_ARB_DDR_EN
  logic [1:0] r32;
  always_ff @(posedge CLK)
    r32 <= (RST || !(keep && owner_id == ID_DDR)) ? 2'b00 : req_rise32;
  assign pin_SDA_oena_rise32 = r32;
`else
  logic unused_ddr;
  assign unused_ddr = ^{req_rise32, req[2]};
  assign pin_SDA_oena_rise32 = 2'b00;
`endif
endmodule

// File: tb/tb_i3c_sda_drive_arb.sv
// tb_i3c_sda_drive_arb: directed self-checking bench for the SDA drive arbiter (TMO_SCL = 4).
module tb_i3c_sda_drive_arb;
  logic CLK = 1'b0;
  logic RST, i_scl_sync;
  logic [2:0] req, req_sda_out, req_oena, req_rise0, req_rise1, gnt;
  logic [1:0] req_rise32, pin_SDA_oena_rise32, owner_id;
  logic pin_SDA_out, pin_SDA_oena, pin_SDA_oena_rise0, pin_SDA_oena_rise1, tmo_err;
  logic [5:0] pins;
  int checks = 0;
  int failures = 0;
  assign pins = {pin_SDA_oena_rise32, pin_SDA_oena_rise1, pin_SDA_oena_rise0, pin_SDA_oena, pin_SDA_out};
  always #5 CLK = ~CLK;
  i3c_sda_drive_arb #(.TMO_SCL(4), .CNT_W(8)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .i_scl_sync         (i_scl_sync),
    .req                (req),
    .req_sda_out        (req_sda_out),
    .req_oena           (req_oena),
    .req_rise0          (req_rise0),
    .req_rise1          (req_rise1),
    .req_rise32         (req_rise32),
    .gnt                (gnt),
    .pin_SDA_out        (pin_SDA_out),
    .pin_SDA_oena       (pin_SDA_oena),
    .pin_SDA_oena_rise0 (pin_SDA_oena_rise0),
    .pin_SDA_oena_rise1 (pin_SDA_oena_rise1),
    .pin_SDA_oena_rise32(pin_SDA_oena_rise32),
    .tmo_err            (tmo_err),
    .owner_id           (owner_id)
  );
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic scl_falls(input int n);
    for (int i = 0; i < n; i++) begin
      i_scl_sync = 1'b0;
      tick();
      i_scl_sync = 1'b1;
      tick();
    end
  endtask
  initial begin
    RST = 1'b1;
    i_scl_sync = 1'b1;
    req = 3'b000;
    req_sda_out = 3'b000;
    req_oena = 3'b000;
    req_rise0 = 3'b000;
    req_rise1 = 3'b000;
    req_rise32 = 2'b00;
    tick();
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_owner", owner_id, 3);
    chk("rst_pins", pins, 0);
    chk("rst_tmo", tmo_err, 0);
    RST = 1'b0;
    req = 3'b011;
    req_sda_out = 3'b001;
    req_oena = 3'b001;
    req_rise0 = 3'b010;
    tick();
    chk("grant0_gnt", gnt, 3'b001);
    chk("grant0_owner", owner_id, 0);
    chk("grant0_pins_first", pins, 0);
    tick();
    chk("own0_pins", pins, 6'b000011);
    req = 3'b010;
    tick();
    chk("handover_idle_gnt", gnt, 0);
    chk("handover_idle_owner", owner_id, 3);
    chk("handover_idle_pins", pins, 0);
    tick();
    chk("grant1_gnt", gnt, 3'b010);
    chk("grant1_owner", owner_id, 1);
    tick();
    chk("own1_pins", pins, 6'b000100);
    req = 3'b011;
    tick();
    chk("no_preempt_gnt", gnt, 3'b010);
    req = 3'b010;
    scl_falls(3);
    i_scl_sync = 1'b0;
    tick();
    chk("tmo_reach_gnt", gnt, 3'b010);
    chk("tmo_reach_err", tmo_err, 0);
    i_scl_sync = 1'b1;
    tick();
    chk("tmo_err_pulse", tmo_err, 1);
    chk("tmo_gnt", gnt, 0);
    chk("tmo_owner", owner_id, 3);
    chk("tmo_pins", pins, 0);
    tick();
    chk("tmo_err_single", tmo_err, 0);
    chk("tmo_idle_gnt", gnt, 0);
    tick();
    chk("masked_gnt", gnt, 0);
    req = 3'b000;
    tick();
    chk("mask_clear_gnt", gnt, 0);
    req = 3'b010;
    tick();
    chk("regrant1_gnt", gnt, 3'b010);
    scl_falls(3);
    i_scl_sync = 1'b0;
    tick();
    req = 3'b000;
    i_scl_sync = 1'b1;
    tick();
    chk("race_gnt", gnt, 0);
    chk("race_tmo", tmo_err, 0);
    chk("race_owner", owner_id, 3);
    tick();
    chk("race_tmo_after", tmo_err, 0);
    req = 3'b010;
    req_oena = 3'b010;
    tick();
    chk("race_nomask_gnt", gnt, 3'b010);
    tick();
    chk("own1b_pins", pins, 6'b000110);
    RST = 1'b1;
    tick();
    chk("midrst_gnt", gnt, 0);
    chk("midrst_owner", owner_id, 3);
    chk("midrst_pins", pins, 0);
    chk("midrst_tmo", tmo_err, 0);
    RST = 1'b0;
    req = 3'b100;
    req_rise32 = 2'b11;
    tick();
`ifdef I3C_SDA_ARB_DDR_EN
    chk("ddr_gnt", gnt, 3'b100);
    chk("ddr_owner", owner_id, 2);
    tick();
    chk("ddr_pins", pins, 6'b110000);
    RST = 1'b1;
    tick();
    chk("ddr_rst_gnt", gnt, 0);
    chk("ddr_rst_owner", owner_id, 3);
    chk("ddr_rst_pins", pins, 0);
    RST = 1'b0;
`else
    chk("noddr_gnt_a", gnt, 0);
    tick();
    tick();
    chk("noddr_gnt_b", gnt, 0);
    chk("noddr_owner", owner_id, 3);
    chk("noddr_pins", pins, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
